// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code synchroniser/decoder.
package gray_pkg;

    // Decoder FSM states
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // Shallowest synchroniser that still gives metastability settling time
    localparam int SYNC_MIN = 2;

    // Widest Gray word the conversion helper handles
    localparam int GRAY_MAX_W = 32;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Narrower words are zero-extended by the caller; zero upper bits leave the
    // low bits unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync_decoder_sync.sv
// N-wide multi-flop synchroniser for a Gray word crossing into the local clock.
module gray_sync
    import gray_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] d_in,
    output logic [N-1:0] q_out
);

    // Depth never drops below the minimum safe chain length
    localparam int DEPTH = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [N-1:0] sync_q [DEPTH];
    logic [N-1:0] sync_d [DEPTH];

    // Each stage takes the previous one; stage 0 takes the raw input
    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q_out = sync_q[DEPTH-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Gray-word consumer: synchronises, converts to binary, flags +/-1 steps and
// wraps. Optional illegal-step checking is enabled by defining STEP_CHECK_EN;
// without it step_err/err_cnt read 0 and err_clr has no effect.
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     gray_in,
    input  logic             err_clr,
    output logic [N-1:0]     bin_out,
    output logic             upd,
    output logic             dir,
    output logic             wrap,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int DEPTH = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // Load happens once the first post-reset sample has crossed the whole chain
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEPTH);

    logic [N-1:0] gs;
    logic [N-1:0] bn;
    logic [N-1:0] diff;
    logic         step_up;
    logic         step_dn;
    logic         jump;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [N-1:0]     prev_q,     prev_d;
    logic [N-1:0]     bin_q,      bin_d;
    logic             upd_q,      upd_d;
    logic             dir_q,      dir_d;
    logic             wrap_q,     wrap_d;
`ifdef STEP_CHECK_EN
    logic             step_err_q, step_err_d;
    logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
`endif

    gray_sync #(
        .N           (N),
        .SYNC_STAGES (DEPTH)
    ) u_sync (
        .clk   (clk),
        .rstn  (rstn),
        .d_in  (gray_in),
        .q_out (gs)
    );

    assign bn      = N'(gray2bin(GRAY_MAX_W'(gs)));
    assign diff    = bn - prev_q;
    assign step_up = (diff == N'(1));
    assign step_dn = (diff == '1);
    assign jump    = (diff != '0) && !step_up && !step_dn;

    // Next-state: init settling, step classification and error bookkeeping
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        bin_d      = bin_q;
        upd_d      = 1'b0;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
`ifdef STEP_CHECK_EN
        step_err_d = step_err_q;
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    prev_d     = bn;
                    bin_d      = bn;
                    init_cnt_d = '0;
                    state_d    = S_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                if (step_up) begin
                    prev_d = bn;
                    bin_d  = bn;
                    upd_d  = 1'b1;
                    dir_d  = 1'b1;
                    wrap_d = (prev_q == '1);
                end else if (step_dn) begin
                    prev_d = bn;
                    bin_d  = bn;
                    upd_d  = 1'b1;
                    dir_d  = 1'b0;
                    wrap_d = (prev_q == '0);
                end else if (jump) begin
                    // Resynchronise to whatever arrived
                    prev_d = bn;
                    bin_d  = bn;
                    upd_d  = 1'b1;
`ifdef STEP_CHECK_EN
                    dir_d  = 1'b0;
`else
                    dir_d  = ~diff[N-1];
`endif
                end
            end
        endcase
`ifdef STEP_CHECK_EN
        if (err_clr) begin
            step_err_d = 1'b0;
            err_cnt_d  = '0;
            if (state_q == S_FAULT) begin
                state_d = S_TRACK;
            end
        end
        // A fresh illegal step overrides a simultaneous clear
        if (state_q != S_INIT && jump) begin
            step_err_d = 1'b1;
            err_cnt_d  = err_clr ? ERR_W'(1)
                       : ((err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1);
            state_d    = S_FAULT;
        end
`endif
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            prev_q     <= '0;
            bin_q      <= '0;
            upd_q      <= 1'b0;
            dir_q      <= 1'b0;
            wrap_q     <= 1'b0;
`ifdef STEP_CHECK_EN
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            bin_q      <= bin_d;
            upd_q      <= upd_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
`ifdef STEP_CHECK_EN
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign bin_out = bin_q;
    assign upd     = upd_q;
    assign dir     = dir_q;
    assign wrap    = wrap_q;
`ifdef STEP_CHECK_EN
    assign step_err = step_err_q;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign step_err       = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Bench for gray_sync_decoder (N=4, SYNC_STAGES=2, ERR_W=8). Checks against a
// cycle-level reference model; STEP_CHECK_EN selects the expected error rules.
module tb_gray_sync_decoder;

    localparam int N           = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_W       = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     gray_in;
    logic             err_clr;
    logic [N-1:0]     bin_out;
    logic             upd;
    logic             dir;
    logic             wrap;
    logic             step_err;
    logic [ERR_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    int h0, h1;          // Gray values captured at the last two edges
    bit m_track;         // model knows the tracked position
    bit m_known;         // bin_out is predictable
    int m_pos;
    bit m_upd, m_dir, m_wrap, m_err;
    int m_cnt;

    gray_sync_decoder #(
        .N           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .ERR_W       (ERR_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .bin_out  (bin_out),
        .upd      (upd),
        .dir      (dir),
        .wrap     (wrap),
        .step_err (step_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    // inverse of the Gray mapping by exhaustive search
    function automatic int g2b(input int g);
        for (int b = 0; b < 16; b++) begin
            if (b2g(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h0 = 0; h1 = 0;
        m_track = 0; m_known = 1; m_pos = 0;
        m_upd = 0; m_dir = 0; m_wrap = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input int g, input bit clr);
        int seen, b, d;
        bit ill;
        if (!rstn) begin
            model_reset();
            return;
        end
        seen = h1; h1 = h0; h0 = g;
        m_upd = 0; m_wrap = 0; ill = 0;
        if (m_track) begin
            b = g2b(seen);
            d = (b - m_pos + 16) % 16;
            if (d == 1) begin
                m_upd = 1; m_dir = 1; m_wrap = (m_pos == 15); m_pos = b;
            end else if (d == 15) begin
                m_upd = 1; m_dir = 0; m_wrap = (m_pos == 0); m_pos = b;
            end else if (d != 0) begin
                m_upd = 1; ill = 1; m_pos = b;
`ifdef STEP_CHECK_EN
                m_dir = 0;
`else
                m_dir = (d < 8);
`endif
            end
        end
`ifdef STEP_CHECK_EN
        if (clr) begin m_err = 0; m_cnt = 0; end
        if (ill) begin m_err = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
`endif
    endtask

    task automatic check_outputs();
        if (m_known) chk("bin_out", int'(bin_out), m_pos);
        chk("upd", int'(upd), int'(m_upd));
        if (m_upd) chk("dir", int'(dir), int'(m_dir));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("step_err", int'(step_err), int'(m_err));
        chk("err_cnt", int'(err_cnt), m_cnt);
    endtask

    task automatic step(input int g, input bit clr);
        gray_in = 4'(g);
        err_clr = clr;
        @(posedge clk);
        #1;
        model_edge(g, clr);
        check_outputs();
    endtask

    task automatic do_release(input int g);
        rstn = 1'b1;
        m_known = 0;
        for (int i = 0; i < 6; i++) step(g, 0);
        m_track = 1; m_known = 1; m_pos = g2b(g);
    endtask

    logic [3:0] up_seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    initial begin
        int nupd, nwrap, cur_b, r;
        bit exp_en;
`ifdef STEP_CHECK_EN
        exp_en = 1;
`else
        exp_en = 0;
`endif
        // reset with a non-zero Gray word present
        rstn = 1'b0; gray_in = 4'h5; err_clr = 1'b0;
        model_reset();
        step(5, 0);
        step(5, 0);
        chk("rst_bin", int'(bin_out), 0);
        chk("rst_dir", int'(dir), 0);
        step(0, 0);
        step(0, 0);
        do_release(0);
        for (int i = 0; i < 10; i++) step(0, 0);
        chk("idle_bin", int'(bin_out), 0);

        // full up-count sequence including the wrap
        nupd = 0; nwrap = 0;
        for (int i = 0; i < 17; i++) begin
            step(int'(up_seq[i]), 0);
            nupd += int'(upd); nwrap += int'(wrap);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            nupd += int'(upd); nwrap += int'(wrap);
        end
        chk("up_upd_count", nupd, 16);
        chk("up_wrap_count", nwrap, 1);
        chk("up_final_bin", int'(bin_out), 0);

        // down steps: 0 -> 15 with wrap, 15 -> 14 without
        step(8, 0); step(8, 0); step(8, 0);
        chk("dn_bin", int'(bin_out), 15);
        chk("dn_upd", int'(upd), 1);
        chk("dn_dir", int'(dir), 0);
        chk("dn_wrap", int'(wrap), 1);
        step(9, 0); step(9, 0); step(9, 0);
        chk("dn2_bin", int'(bin_out), 14);
        chk("dn2_dir", int'(dir), 0);
        chk("dn2_wrap", int'(wrap), 0);

        // illegal jump 1 -> 6, clear, then clear colliding with a new jump
        for (int i = 0; i < 4; i++) step(1, 0);
        step(1, 1);
        step(1, 0);
        step(5, 0); step(5, 0); step(5, 0);
        chk("jmp_bin", int'(bin_out), 6);
        chk("jmp_upd", int'(upd), 1);
        chk("jmp_dir", int'(dir), exp_en ? 0 : 1);
        chk("jmp_err", int'(step_err), exp_en ? 1 : 0);
        chk("jmp_cnt", int'(err_cnt), exp_en ? 1 : 0);
        step(5, 1);
        chk("clr_err", int'(step_err), 0);
        chk("clr_cnt", int'(err_cnt), 0);
        step(15, 0); step(15, 0); step(15, 0); step(15, 0);
        step(0, 0); step(0, 0); step(0, 1);
        chk("clrjmp_upd", int'(upd), 1);
        chk("clrjmp_err", int'(step_err), exp_en ? 1 : 0);
        chk("clrjmp_cnt", int'(err_cnt), exp_en ? 1 : 0);
        step(0, 0); step(0, 0);

        // saturation: 300 illegal changes
        for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 7 : 0, 0);
        step(0, 0); step(0, 0); step(0, 0);
        chk("sat_cnt", int'(err_cnt), exp_en ? 255 : 0);
        chk("sat_err", int'(step_err), exp_en ? 1 : 0);
        step(0, 1);
        chk("sat_clr_cnt", int'(err_cnt), 0);

        // randomized walk: mostly legal steps, some jumps and clears
        cur_b = 0;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3)      cur_b = (cur_b + 1) % 16;
            else if (r <= 6) cur_b = (cur_b + 15) % 16;
            else if (r == 8) cur_b = int'($urandom_range(0, 15));
            step(b2g(cur_b), ($urandom_range(0, 7) == 0));
        end
        step(b2g(cur_b), 0); step(b2g(cur_b), 0); step(b2g(cur_b), 0);

        // reset mid-run at position 9
        for (int i = 0; i < 4; i++) step(13, 0);
        chk("pre_rst_bin", int'(bin_out), 9);
        #3;
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("mid_rst_dir", int'(dir), 0);
        step(13, 0); step(13, 0);
        do_release(13);
        for (int i = 0; i < 10; i++) step(13, 0);
        chk("reinit_bin", int'(bin_out), 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
